// File: rtl/tick_div_pkg.sv
// Shared defaults, per-channel state record and helpers for the tick divider bank.
// The optional toggle output is enabled with the TICK_DIV_TOGGLE_EN macro.
package tick_div_pkg;

    localparam int NUM_CH_DEF    = 4;
    localparam int CNT_W_DEF     = 16;
    localparam int DIV_RESET_DEF = 15;

    // State fields are sized for the widest supported counter; narrower builds leave upper bits at zero
    localparam int MAX_CNT_W = 32;

    typedef struct packed {
        logic [MAX_CNT_W-1:0] cnt;
        logic [MAX_CNT_W-1:0] term;
        logic [MAX_CNT_W-1:0] shad;
    } ch_state_t;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_div_if.sv
// Divide-value load bus: a one-cycle strobe carrying a channel select and a new terminal count.
interface tick_div_if
    import tick_div_pkg::*;
#(
    parameter int SEL_W = sel_width(NUM_CH_DEF),
    parameter int CNT_W = CNT_W_DEF
);
    logic             div_load;
    logic [SEL_W-1:0] div_sel;
    logic [CNT_W-1:0] div_val;

    modport master (output div_load, output div_sel, output div_val);
    modport slave  (input  div_load, input  div_sel, input  div_val);
endinterface

// File: rtl/tick_div_channel.sv
// One divider channel: counter, active terminal and shadow terminal, registered tick.
// TICK_DIV_TOGGLE_EN adds a square-wave output that flips on every tick.
module tick_div_channel
    import tick_div_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int DIV_RESET = DIV_RESET_DEF
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] val,
    input  logic             restart,
`ifdef TICK_DIV_TOGGLE_EN
    output logic             tog_out,
`endif
    output logic             tick_out
);

    ch_state_t            state_q, state_d;
    logic                 tick_q, tick_d;
    logic                 wrap;
    logic [MAX_CNT_W-1:0] wide_val;

    // ">=" keeps the counter from running past a terminal that was lowered while the channel was idle
    assign wrap     = en && (state_q.cnt >= state_q.term);
    assign wide_val = MAX_CNT_W'(val);

    always_comb begin
        state_d = state_q;
        tick_d  = 1'b0;
        if (load) begin
            state_d.shad = wide_val;
        end
        if (restart) begin
            state_d.cnt  = '0;
            state_d.term = load ? wide_val : state_q.shad;
        end else begin
            tick_d = wrap;
            if (en) begin
                state_d.cnt = wrap ? '0 : state_q.cnt + MAX_CNT_W'(1);
            end
            // New terminals only land on a period boundary or while the channel is stopped
            if (load && (wrap || !en)) begin
                state_d.term = wide_val;
            end else if (wrap) begin
                state_d.term = state_q.shad;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q.cnt  <= '0;
            state_q.term <= MAX_CNT_W'(DIV_RESET);
            state_q.shad <= MAX_CNT_W'(DIV_RESET);
            tick_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
        end
    end

    assign tick_out = tick_q;

`ifdef TICK_DIV_TOGGLE_EN
    logic tog_q, tog_d;

    always_comb begin
        tog_d = restart ? 1'b0 : (tog_q ^ wrap);
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            tog_q <= 1'b0;
        end else begin
            tog_q <= tog_d;
        end
    end

    assign tog_out = tog_q;
`endif

endmodule

// File: rtl/tick_divider_bank.sv
// Bank of NUM_CH independent programmable tick dividers sharing one load bus and restart.
// Defining TICK_DIV_TOGGLE_EN adds the tog_out square-wave port.
module tick_divider_bank
    import tick_div_pkg::*;
#(
    parameter int NUM_CH    = NUM_CH_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int DIV_RESET = DIV_RESET_DEF
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] en,
    tick_div_if.slave         cfg,
    input  logic              restart,
`ifdef TICK_DIV_TOGGLE_EN
    output logic [NUM_CH-1:0] tog_out,
`endif
    output logic [NUM_CH-1:0] tick_out
);

    logic [NUM_CH-1:0] load_vec;

    // Selects that do not name an existing channel decode to no load at all
    always_comb begin
        load_vec = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (cfg.div_load && (int'(cfg.div_sel) == c)) begin
                load_vec[c] = 1'b1;
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        tick_div_channel #(
            .CNT_W     (CNT_W),
            .DIV_RESET (DIV_RESET)
        ) u_ch (
            .clk_in   (clk_in),
            .rst_n    (rst_n),
            .en       (en[c]),
            .load     (load_vec[c]),
            .val      (cfg.div_val),
            .restart  (restart),
`ifdef TICK_DIV_TOGGLE_EN
            .tog_out  (tog_out[c]),
`endif
            .tick_out (tick_out[c])
        );
    end

endmodule
